// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - 4-master round-robin AHB arbiter with burst-aware handover.
// Define AHB_ARB_LOCK_EN to add the hlock input and locked-transfer support.
module ahb_arbiter (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [3:0] hbusreq,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  input  logic [1:0] hresp,
  output logic [3:0] hgrant,
  output logic [1:0] hmaster,
  output logic       hmastlock
`ifdef AHB_ARB_LOCK_EN
  ,
  input  logic [3:0] hlock
`endif
);

  typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_t;

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hgrant_q, hgrant_d;
  logic [1:0] hmaster_q, hmaster_d;
  logic [1:0] grant_idx;
  logic [1:0] winner;
  logic       last_beat;
  logic       lock_hold;
  logic       rearb_ok;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] cur);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = cur + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = hlock[hmaster_q] & hbusreq[hmaster_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    grant_idx = onehot_to_idx(hgrant_q);
    // Search from the granted index (it leads hmaster by a cycle) so each edge advances one slot.
    winner    = rr_pick(hbusreq, grant_idx);
    last_beat = (hburst >= 3'd2) && (htrans == TR_SEQ) && (cnt_q == 4'd1);
    rearb_ok  = hready && !lock_hold &&
                ((state_q == PARK) ||
                 (htrans == TR_IDLE) ||
                 (!hbusreq[hmaster_q] && (htrans != TR_SEQ)) ||
                 ((hburst < 3'd2) && (htrans != TR_SEQ)) ||
                 last_beat ||
                 (hresp == RESP_ERROR));
  end

  always_comb begin
    state_d   = state_q;
    hgrant_d  = hgrant_q;
    hmaster_d = hmaster_q;
    cnt_d     = cnt_q;

    if (rearb_ok) begin
      if (hbusreq == 4'b0000) begin
        state_d = PARK;
      end else begin
        hgrant_d = 4'b0001 << winner;
        state_d  = OWN;
      end
    end

    if (hready) begin
      hmaster_d = grant_idx;
      if (hresp == RESP_ERROR) begin
        cnt_d = 4'd0;
      end else if (htrans == TR_NONSEQ) begin
        case (hburst[2:1])
          2'b01:   cnt_d = 4'd3;
          2'b10:   cnt_d = 4'd7;
          2'b11:   cnt_d = 4'd15;
          default: cnt_d = 4'd0;
        endcase
      end else if ((htrans == TR_SEQ) && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= PARK;
      cnt_q     <= 4'd0;
      hgrant_q  <= 4'b0001;
      hmaster_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hgrant_q  <= hgrant_d;
      hmaster_q <= hmaster_d;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  logic hmastlock_q, hmastlock_d;

  always_comb begin
    hmastlock_d = hmastlock_q;
    if (hready) hmastlock_d = hlock[grant_idx];
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) hmastlock_q <= 1'b0;
    else        hmastlock_q <= hmastlock_d;
  end

  assign hmastlock = hmastlock_q;
`else
  assign hmastlock = 1'b0;
`endif

  assign hgrant  = hgrant_q;
  assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter; lock scenario built with AHB_ARB_LOCK_EN.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] ERR    = 2'b01;

  logic       hclk;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;
`ifdef AHB_ARB_LOCK_EN
  logic [3:0] hlock;
`endif

  int tests_run;
  int tests_failed;

  // Expected {hmastlock, hgrant, hmaster} per cycle, pushed as stimulus is driven.
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  string      tag_q[$];

  ahb_arbiter dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
`ifdef AHB_ARB_LOCK_EN
    .hlock     (hlock),
`endif
    .hmastlock (hmastlock)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic step(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [1:0] rs, input logic [6:0] exp_v,
                      input string tag);
    hbusreq = req;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rs;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge hclk);
    #1;
    obs_q.push_back({hmastlock, hgrant, hmaster});
  endtask

  task automatic do_reset();
    hbusreq = 4'b0000;
    htrans  = IDLE;
    hburst  = 3'd0;
    hready  = 1'b1;
    hresp   = OKAY;
`ifdef AHB_ARB_LOCK_EN
    hlock   = 4'b0000;
`endif
    hreset  = 1'b1;
    #2;
    hreset  = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e, o;
    string t;
    hbusreq = 4'b0000;
    htrans  = IDLE;
    hburst  = 3'd0;
    hready  = 1'b1;
    hresp   = OKAY;
`ifdef AHB_ARB_LOCK_EN
    hlock   = 4'b0000;
`endif
    hreset  = 1'b0;
    #1 hreset = 1'b1;
    #2;
    tests_run++;
    if ({hmastlock, hgrant, hmaster} !== {1'b0, 4'b0001, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b_%b_%0d expected 0_0001_0", hmastlock, hgrant, hmaster);
    end
    tests_run++;
    if (dut.cnt_q !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_counter: got %0d expected 0", dut.cnt_q);
    end
    @(posedge hclk);
    #1 hreset = 1'b0;
    for (int i = 0; i < 6; i++) step(4'b0000, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0001, 2'd0}, "idle_park");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] e, o;
    logic [3:0] g;
    string t;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      g = 4'b0001 << (k % 4);
      step(4'b1111, NONSEQ, 3'd0, 1'b1, OKAY, {1'b0, g, 2'((k - 1) % 4)}, "round_robin");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e, o;
    string t;
    do_reset();
    step(4'b0100, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd0}, "incr8_grant");
    step(4'b0100, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "incr8_owner");
    step(4'b0100, NONSEQ, 3'd5, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "incr8_nonseq");
    tests_run++;
    if (dut.cnt_q !== 4'd7) begin
      tests_failed++;
      $display("FAIL incr8_load: counter %0d expected 7", dut.cnt_q);
    end
    for (int i = 0; i < 6; i++) step(4'b0110, SEQ, 3'd5, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "incr8_hold");
    tests_run++;
    if (dut.cnt_q !== 4'd1) begin
      tests_failed++;
      $display("FAIL incr8_penult: counter %0d expected 1", dut.cnt_q);
    end
    step(4'b0110, SEQ, 3'd5, 1'b1, OKAY, {1'b0, 4'b0010, 2'd2}, "incr8_handover");
    tests_run++;
    if (dut.cnt_q !== 4'd0) begin
      tests_failed++;
      $display("FAIL incr8_done: counter %0d expected 0", dut.cnt_q);
    end
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "incr8_new_owner");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

  task automatic test_hready_stall();
    logic [6:0] e, o;
    string t;
    do_reset();
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd0}, "stall_grant");
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "stall_owner");
    step(4'b0110, NONSEQ, 3'd3, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "stall_beat1");
    step(4'b0110, SEQ, 3'd3, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "stall_beat2");
    for (int i = 0; i < 3; i++) step(4'b0110, SEQ, 3'd3, 1'b0, OKAY, {1'b0, 4'b0010, 2'd1}, "stall_frozen");
    tests_run++;
    if (dut.cnt_q !== 4'd2) begin
      tests_failed++;
      $display("FAIL stall_counter: counter %0d expected 2", dut.cnt_q);
    end
    step(4'b0110, SEQ, 3'd3, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "stall_beat3");
    step(4'b0110, SEQ, 3'd3, 1'b1, OKAY, {1'b0, 4'b0100, 2'd1}, "stall_beat4_handover");
    step(4'b0100, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "stall_new_owner");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

  task automatic test_error();
    logic [6:0] e, o;
    string t;
    do_reset();
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd0}, "err_grant");
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "err_owner");
    step(4'b1010, NONSEQ, 3'd6, 1'b1, OKAY, {1'b0, 4'b0010, 2'd1}, "err_wrap16_start");
    tests_run++;
    if (dut.cnt_q !== 4'd15) begin
      tests_failed++;
      $display("FAIL err_load: counter %0d expected 15", dut.cnt_q);
    end
    step(4'b1010, SEQ, 3'd6, 1'b1, ERR, {1'b0, 4'b1000, 2'd1}, "err_abort");
    tests_run++;
    if (dut.cnt_q !== 4'd0) begin
      tests_failed++;
      $display("FAIL err_clear: counter %0d expected 0", dut.cnt_q);
    end
    step(4'b1000, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b1000, 2'd3}, "err_new_owner");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] e, o;
    string t;
    do_reset();
    step(4'b0100, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd0}, "rst_grant");
    step(4'b0100, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "rst_owner");
    step(4'b0100, NONSEQ, 3'd7, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "rst_incr16_start");
    for (int i = 0; i < 3; i++) step(4'b0100, SEQ, 3'd7, 1'b1, OKAY, {1'b0, 4'b0100, 2'd2}, "rst_incr16_beat");
    tests_run++;
    if (dut.cnt_q !== 4'd12) begin
      tests_failed++;
      $display("FAIL rst_mid_counter: counter %0d expected 12", dut.cnt_q);
    end
    #2 hreset = 1'b1;
    #1;
    tests_run++;
    if ({hmastlock, hgrant, hmaster, dut.cnt_q} !== {1'b0, 4'b0001, 2'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL rst_async: got %b_%b_%0d cnt %0d expected 0_0001_0 cnt 0",
               hmastlock, hgrant, hmaster, dut.cnt_q);
    end
    hreset = 1'b0;
    step(4'b0000, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0001, 2'd0}, "rst_idle");
    step(4'b1000, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b1000, 2'd0}, "rst_resume_grant");
    step(4'b1000, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b1000, 2'd3}, "rst_resume_owner");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask

`ifdef AHB_ARB_LOCK_EN
  task automatic test_lock();
    logic [6:0] e, o;
    string t;
    do_reset();
    hlock = 4'b0010;
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b0, 4'b0010, 2'd0}, "lock_grant");
    step(4'b0010, IDLE, 3'd0, 1'b1, OKAY, {1'b1, 4'b0010, 2'd1}, "lock_owner");
    for (int i = 0; i < 3; i++) step(4'b1111, NONSEQ, 3'd0, 1'b1, OKAY, {1'b1, 4'b0010, 2'd1}, "lock_hold");
    hlock = 4'b0000;
    step(4'b1111, NONSEQ, 3'd0, 1'b1, OKAY, {1'b0, 4'b0100, 2'd1}, "lock_release");
    step(4'b1111, NONSEQ, 3'd0, 1'b1, OKAY, {1'b0, 4'b1000, 2'd2}, "lock_rotate");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b", t, o, e);
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_hready_stall();
    test_error();
    test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
